// File: rtl/pool_pkg.sv
// Shared constants, layer state codes and per-layer window geometry for the max-pool sequencer.
package pool_pkg;

    localparam int DATSIZE = 22;
    localparam int FPSHIFT = 14;

    localparam logic [3:0] ST_POOL1 = 4'b0011;
    localparam logic [3:0] ST_POOL2 = 4'b0101;
    localparam logic [3:0] ST_POOL3 = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } fsm_t;

    // Loop limits are stored as last indices so the counters compare against them directly.
    typedef struct packed {
        logic [1:0] k_log2;
        logic [1:0] ky_last;
        logic       kx_last;
        logic [4:0] o_last;
        logic [5:0] c_last;
    } layer_cfg_t;

    function automatic logic is_pool_state(input logic [3:0] code);
        return (code == ST_POOL1) || (code == ST_POOL2) || (code == ST_POOL3);
    endfunction

    function automatic layer_cfg_t layer_cfg(input logic [3:0] code);
        layer_cfg_t cfg;
        case (code)
            ST_POOL2: cfg = '{k_log2: 2'd1, ky_last: 2'd1, kx_last: 1'b0, o_last: 5'd7,  c_last: 6'd31};
            ST_POOL3: cfg = '{k_log2: 2'd2, ky_last: 2'd3, kx_last: 1'b1, o_last: 5'd1,  c_last: 6'd63};
            default:  cfg = '{k_log2: 2'd1, ky_last: 2'd1, kx_last: 1'b0, o_last: 5'd15, c_last: 6'd15};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/pool_engine_max_acc.sv
// Pair max and window accumulator, with the window coordinates delayed to line up with the read data.
module pool_max_acc
    import pool_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic                   rd_first,
    input  logic                   rd_last,
    input  logic [4:0]             rd_y,
    input  logic [4:0]             rd_x,
    input  logic [5:0]             rd_c,
    input  logic [2*DATSIZE-1:0]   rd_data,
    output logic                   cw_en,
    output logic [4:0]             cw_y,
    output logic [4:0]             cw_x,
    output logic [5:0]             cw_c,
    output logic [DATSIZE-1:0]     cw_data
);

    logic [DATSIZE-1:0] half [2];
    logic [DATSIZE-1:0] pair_max;
    logic [DATSIZE-1:0] acc_reg;
    logic [DATSIZE-1:0] acc_next;
    logic               s1_valid_reg;
    logic               s1_first_reg;
    logic               s1_last_reg;
    logic [4:0]         s1_y_reg;
    logic [4:0]         s1_x_reg;
    logic [5:0]         s1_c_reg;
    logic               wr_now;

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half[gi] = rd_data[gi*DATSIZE +: DATSIZE];
    end

    assign pair_max = ($signed(half[1]) > $signed(half[0])) ? half[1] : half[0];
    // The first read of a window must not compare against the previous window's result.
    assign acc_next = (s1_first_reg || ($signed(pair_max) > $signed(acc_reg))) ? pair_max : acc_reg;
    assign wr_now   = s1_valid_reg && s1_last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_y_reg     <= '0;
            s1_x_reg     <= '0;
            s1_c_reg     <= '0;
            acc_reg      <= '0;
            cw_en        <= 1'b0;
            cw_y         <= '0;
            cw_x         <= '0;
            cw_c         <= '0;
            cw_data      <= '0;
        end else begin
            s1_valid_reg <= rd_en;
            s1_first_reg <= rd_en && rd_first;
            s1_last_reg  <= rd_en && rd_last;
            s1_y_reg     <= rd_y;
            s1_x_reg     <= rd_x;
            s1_c_reg     <= rd_c;
            if (s1_valid_reg) begin
                acc_reg <= acc_next;
            end
            cw_en   <= wr_now;
            cw_y    <= wr_now ? s1_y_reg : '0;
            cw_x    <= wr_now ? s1_x_reg : '0;
            cw_c    <= wr_now ? s1_c_reg : '0;
            cw_data <= wr_now ? acc_next : '0;
        end
    end

endmodule

// File: rtl/pool_engine.sv
// Max-pool sequencer: layer FSM and nested c/oy/ox/ky/kx read counters feeding the max accumulator.
module pool_engine
    import pool_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             state,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pr_en,
    output logic [5:0]             pr_y,
    output logic [5:0]             pr_x,
    output logic [5:0]             pr_c,
    output logic                   pr_updown,
    input  logic [2*DATSIZE-1:0]   pr_data,
    output logic                   cw_en,
    output logic [4:0]             cw_y,
    output logic [4:0]             cw_x,
    output logic [5:0]             cw_c,
    output logic [DATSIZE-1:0]     cw_data
);

    fsm_t       state_reg, state_next;
    layer_cfg_t cfg_reg;
    logic [5:0] c_reg;
    logic [4:0] oy_reg, ox_reg;
    logic [1:0] ky_reg;
    logic       kx_reg;
    logic       start_ok, rd_active;
    logic       kx_wrap, ky_wrap, ox_wrap, oy_wrap, c_wrap;
    logic       win_first, win_last, run_last;
    logic [6:0] row_sum;
    logic [5:0] col_sum;

    assign start_ok  = start && (state_reg == S_IDLE) && is_pool_state(state);
    assign rd_active = (state_reg == S_RUN);

    assign kx_wrap   = (kx_reg == cfg_reg.kx_last);
    assign ky_wrap   = (ky_reg == cfg_reg.ky_last);
    assign ox_wrap   = (ox_reg == cfg_reg.o_last);
    assign oy_wrap   = (oy_reg == cfg_reg.o_last);
    assign c_wrap    = (c_reg  == cfg_reg.c_last);
    assign win_first = (kx_reg == 1'b0) && (ky_reg == 2'd0);
    assign win_last  = kx_wrap && ky_wrap;
    assign run_last  = win_last && ox_wrap && oy_wrap && c_wrap;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (run_last) state_next = S_DRAIN;
            // With at least two reads per window, the only write seen here is the final one.
            S_DRAIN: if (cw_en)    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg <= '0;
            c_reg   <= '0;
            oy_reg  <= '0;
            ox_reg  <= '0;
            ky_reg  <= '0;
            kx_reg  <= 1'b0;
        end else if (start_ok) begin
            cfg_reg <= layer_cfg(state);
            c_reg   <= '0;
            oy_reg  <= '0;
            ox_reg  <= '0;
            ky_reg  <= '0;
            kx_reg  <= 1'b0;
        end else if (rd_active) begin
            if (!kx_wrap) begin
                kx_reg <= kx_reg + 1'b1;
            end else begin
                kx_reg <= 1'b0;
                if (!ky_wrap) begin
                    ky_reg <= ky_reg + 2'd1;
                end else begin
                    ky_reg <= '0;
                    if (!ox_wrap) begin
                        ox_reg <= ox_reg + 5'd1;
                    end else begin
                        ox_reg <= '0;
                        if (!oy_wrap) begin
                            oy_reg <= oy_reg + 5'd1;
                        end else begin
                            oy_reg <= '0;
                            c_reg  <= c_wrap ? 6'd0 : c_reg + 6'd1;
                        end
                    end
                end
            end
        end
    end

    // Row = K*oy + ky; its LSB picks the row of the stored pair. Column pair = (K/2)*ox + kx.
    assign row_sum = ({2'b00, oy_reg} << cfg_reg.k_log2) + {5'b00000, ky_reg};
    assign col_sum = ({1'b0, ox_reg} << (cfg_reg.k_log2 - 2'd1)) + {5'b00000, kx_reg};

    assign pr_en     = rd_active;
    assign pr_y      = rd_active ? row_sum[6:1] : '0;
    assign pr_updown = rd_active & ky_reg[0];
    assign pr_x      = rd_active ? col_sum : '0;
    assign pr_c      = rd_active ? c_reg : '0;
    assign busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);

    pool_max_acc u_max_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_active),
        .rd_first (win_first),
        .rd_last  (win_last),
        .rd_y     (oy_reg),
        .rd_x     (ox_reg),
        .rd_c     (c_reg),
        .rd_data  (pr_data),
        .cw_en    (cw_en),
        .cw_y     (cw_y),
        .cw_x     (cw_x),
        .cw_c     (cw_c),
        .cw_data  (cw_data)
    );

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: a pixel-array buffer model and a window-max reference model.
module tb_pool_engine;
    import pool_pkg::*;

    localparam int D = DATSIZE;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [3:0]            state = 4'd0;
    logic                  start = 1'b0;
    logic                  busy, done, pr_en, pr_updown, cw_en;
    logic [5:0]            pr_y, pr_x, pr_c, cw_c;
    logic [4:0]            cw_y, cw_x;
    logic [2*D-1:0]        pr_data = '0;
    logic [D-1:0]          cw_data;

    int vectors = 0;
    int miscompares = 0;

    logic signed [D-1:0] mem [0:63][0:31][0:31];

    typedef struct {
        int y; int x; int c;
        logic signed [D-1:0] v;
    } wr_t;
    typedef struct {
        int y; int x; int c; int ud;
    } rd_t;

    always #5 clk = ~clk;

    pool_engine dut (
        .clk(clk), .rst_n(rst_n), .state(state), .start(start), .busy(busy), .done(done),
        .pr_en(pr_en), .pr_y(pr_y), .pr_x(pr_x), .pr_c(pr_c), .pr_updown(pr_updown),
        .pr_data(pr_data), .cw_en(cw_en), .cw_y(cw_y), .cw_x(cw_x), .cw_c(cw_c), .cw_data(cw_data)
    );

    // Pooling buffer: row = 2*pr_y + updown, the pair covers columns 2*pr_x and 2*pr_x+1.
    always @(posedge clk) begin
        if (pr_en) begin
            pr_data <= {mem[pr_c][{pr_y, pr_updown}][{pr_x, 1'b1}],
                        mem[pr_c][{pr_y, pr_updown}][{pr_x, 1'b0}]};
        end
    end

    task automatic fill_random();
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    mem[c][y][x] = D'($urandom);
    endtask

    // Runs one layer; abort_cyc > 0 pulls rst_n low at that cycle, inject_cyc > 0 pulses a stray start.
    task automatic run_layer(input logic [3:0] code, input int inject_cyc, input int abort_cyc);
        int K, O, C, R, N;
        wr_t wq[$];
        rd_t rq[$];
        wr_t w;
        rd_t r;
        logic [3:0] exp_flags, got_flags;
        logic signed [D-1:0] m;
        K = (code == ST_POOL3) ? 4 : 2;
        O = (code == ST_POOL1) ? 16 : (code == ST_POOL2) ? 8 : 2;
        C = (code == ST_POOL1) ? 16 : (code == ST_POOL2) ? 32 : 64;
        R = K * K / 2;
        N = C * O * O * R;
        for (int c = 0; c < C; c++)
            for (int oy = 0; oy < O; oy++)
                for (int ox = 0; ox < O; ox++) begin
                    m = mem[c][K*oy][K*ox];
                    for (int dy = 0; dy < K; dy++)
                        for (int dx = 0; dx < K; dx++)
                            if (mem[c][K*oy+dy][K*ox+dx] > m) m = mem[c][K*oy+dy][K*ox+dx];
                    wq.push_back('{y: oy, x: ox, c: c, v: m});
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K / 2; kx++)
                            rq.push_back('{y: (K*oy + ky) / 2, x: (K*ox + 2*kx) / 2, c: c, ud: ky % 2});
                end

        @(posedge clk); #1;
        state = code;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        state = 4'($urandom);

        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if ({busy, done, pr_en, pr_updown, pr_y, pr_x, pr_c, cw_en, cw_y, cw_x, cw_c, cw_data} !== '0) begin
                    miscompares++;
                    $display("FAIL abort_outputs: busy=%0b done=%0b pr_en=%0b cw_en=%0b cw_data=%0h, required all zero",
                             busy, done, pr_en, cw_en, cw_data);
                end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    vectors++;
                    if ({busy, done, pr_en, cw_en} !== 4'b0000) begin
                        miscompares++;
                        $display("FAIL abort_quiet: busy/done/pr_en/cw_en=%b, required 0000", {busy, done, pr_en, cw_en});
                    end
                end
                return;
            end
            exp_flags[3] = (cyc <= N + 2);
            exp_flags[2] = (cyc == N + 3);
            exp_flags[1] = (cyc <= N);
            exp_flags[0] = (cyc >= R + 2) && (cyc <= N + 2) && ((cyc - 2) % R == 0);
            got_flags = {busy, done, pr_en, cw_en};
            vectors++;
            if (got_flags !== exp_flags) begin
                miscompares++;
                $display("FAIL flags cyc=%0d: busy/done/pr_en/cw_en=%b, required %b", cyc, got_flags, exp_flags);
            end
            if (pr_en && exp_flags[1] && rq.size() > 0) begin
                r = rq.pop_front();
                vectors++;
                if ({pr_y, pr_x, pr_c, pr_updown} !== {6'(r.y), 6'(r.x), 6'(r.c), 1'(r.ud)}) begin
                    miscompares++;
                    $display("FAIL read_addr cyc=%0d: y=%0d x=%0d c=%0d ud=%0d, required y=%0d x=%0d c=%0d ud=%0d",
                             cyc, pr_y, pr_x, pr_c, pr_updown, r.y, r.x, r.c, r.ud);
                end
            end else if (!pr_en) begin
                vectors++;
                if ({pr_y, pr_x, pr_c, pr_updown} !== '0) begin
                    miscompares++;
                    $display("FAIL read_idle cyc=%0d: y=%0d x=%0d c=%0d ud=%0d, required 0", cyc, pr_y, pr_x, pr_c, pr_updown);
                end
            end
            if (cw_en && exp_flags[0] && wq.size() > 0) begin
                w = wq.pop_front();
                vectors++;
                if ({cw_y, cw_x, cw_c, cw_data} !== {5'(w.y), 5'(w.x), 6'(w.c), w.v}) begin
                    miscompares++;
                    $display("FAIL write cyc=%0d: y=%0d x=%0d c=%0d data=%0d, required y=%0d x=%0d c=%0d data=%0d",
                             cyc, cw_y, cw_x, cw_c, $signed(cw_data), w.y, w.x, w.c, w.v);
                end
            end else if (!cw_en) begin
                vectors++;
                if ({cw_y, cw_x, cw_c, cw_data} !== '0) begin
                    miscompares++;
                    $display("FAIL write_idle cyc=%0d: y=%0d x=%0d c=%0d data=%0h, required 0", cyc, cw_y, cw_x, cw_c, cw_data);
                end
            end
            if (cyc == inject_cyc) begin
                state = ST_POOL3;
                start = 1'b1;
            end
        end
        vectors++;
        if (wq.size() != 0 || rq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: writes=%0d reads=%0d outstanding, required 0 and 0", wq.size(), rq.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, pr_en, pr_y, pr_x, pr_c, pr_updown, cw_en, cw_y, cw_x, cw_c, cw_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b done=%0b pr_en=%0b cw_en=%0b, required all zero", busy, done, pr_en, cw_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, pr_en, cw_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_release: busy/done/pr_en/cw_en=%b, required 0000", {busy, done, pr_en, cw_en});
        end
    endtask

    task automatic test_pool1_ramp();
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    mem[c][y][x] = D'(c*1024 + y*32 + x);
        run_layer(ST_POOL1, 0, 0);
    endtask

    task automatic test_pool2_negative();
        logic signed [D-1:0] pat [4];
        pat[0] = -5; pat[1] = -3; pat[2] = -7; pat[3] = -9;
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    mem[c][y][x] = pat[(y % 2) * 2 + (x % 2)];
        run_layer(ST_POOL2, 0, 0);
    endtask

    task automatic test_signed_compare();
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    mem[c][y][x] = 22'h200000;
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    mem[c][2*y + $urandom_range(0, 1)][2*x + $urandom_range(0, 1)] = 22'h000001;
        run_layer(ST_POOL2, 0, 0);
    endtask

    task automatic test_pool3_single();
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    mem[c][y][x] = -1;
        mem[63][5][6] = 100;
        run_layer(ST_POOL3, 0, 0);
    endtask

    task automatic test_ignored_start();
        @(posedge clk); #1;
        state = 4'b0010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, pr_en, cw_en} !== 4'b0000) begin
                miscompares++;
                $display("FAIL bad_state_start: busy/done/pr_en/cw_en=%b, required 0000", {busy, done, pr_en, cw_en});
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_layer(ST_POOL2, 50, 0);
        fill_random();
        run_layer(ST_POOL3, 300, 0);
    endtask

    task automatic test_reset_abort();
        fill_random();
        run_layer(ST_POOL1, 0, 100);
        fill_random();
        run_layer(ST_POOL1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_pool1_ramp();
        test_pool2_negative();
        test_signed_compare();
        test_pool3_single();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
